// File: rtl/slice_pkg.sv
// Shared constants and helpers for the slice primitive family.
// Holds the architecture names, the offset width rule and the legal-offset check.
package slice_pkg;

   localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";

   function automatic int offset_width(input int in_width);
      return (in_width > 1) ? $clog2(in_width) : 1;
   endfunction

   // A field of out_width bits starting at offset must fit inside the input word.
   function automatic bit is_legal_offset(input int offset, input int in_width,
                                          input int out_width);
      return (offset + out_width) <= in_width;
   endfunction

endpackage

// File: rtl/slice_delay.sv
// Parametrised register delay line, cleared by synchronous active-low reset.
// DEPTH must be at least 1.
module slice_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_data;
         for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/slice_dynamic.sv
// Run-time offset bit slicer: shadow/commit offset register, slice stage and
// a fixed-latency data/valid pipeline.
module slice_dynamic
   import slice_pkg::*;
#(
   parameter string ARCHITECTURE      = ARCH_BEHAVIORAL,
   parameter int    INPUT_DATA_WIDTH  = 8,
   parameter int    OUTPUT_DATA_WIDTH = 5,
   parameter int    NUM_CHANNELS      = 1,
   parameter int    OFFSET_REL_TO_MSB = 1,
   parameter int    DEFAULT_OFFSET    = 1,
   parameter int    LATENCY           = 1,
   localparam int   OFFSET_WIDTH      = offset_width(INPUT_DATA_WIDTH)
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_CHANNELS*INPUT_DATA_WIDTH-1:0]  data_in,
   input  logic                                      data_in_valid,
   input  logic                                      sync,
   input  logic [OFFSET_WIDTH-1:0]                   offset_in,
   input  logic                                      offset_load,
   output logic [NUM_CHANNELS*OUTPUT_DATA_WIDTH-1:0] data_out,
   output logic                                      data_out_valid,
   output logic [OFFSET_WIDTH-1:0]                   offset_active,
   output logic                                      offset_pending,
   output logic                                      offset_err
);

   localparam int IW = INPUT_DATA_WIDTH;
   localparam int OW = OUTPUT_DATA_WIDTH;
   localparam int DW = NUM_CHANNELS * OUTPUT_DATA_WIDTH;

   logic [OFFSET_WIDTH-1:0] r_active;
   logic [OFFSET_WIDTH-1:0] r_shadow;
   logic                    r_pending;
   logic                    r_err;
   logic [DW-1:0]           r_stage1;
   logic [DW-1:0]           w_slice;
   logic [OFFSET_WIDTH-1:0] w_off_use;
   logic                    w_commit;
   logic                    w_load_legal;

   assign w_commit     = data_in_valid & sync & r_pending;
   // The committing sample is sliced with the shadow value, not the old active one.
   assign w_off_use    = w_commit ? r_shadow : r_active;
   assign w_load_legal = is_legal_offset(int'(offset_in), IW, OW);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active  <= OFFSET_WIDTH'(DEFAULT_OFFSET);
         r_shadow  <= OFFSET_WIDTH'(DEFAULT_OFFSET);
         r_pending <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_commit) r_active <= r_shadow;
         // A load in the commit cycle wins pending, so it survives for the next sync.
         if (offset_load && w_load_legal) begin
            r_shadow  <= offset_in;
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
         if (offset_load && !w_load_legal) r_err <= 1'b1;
      end
   end

   generate
      if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behav
         always_comb begin
            logic [IW-1:0] w_word;
            logic [IW-1:0] w_shifted;
            int            w_shamt;
            w_slice   = '0;
            w_word    = '0;
            w_shifted = '0;
            w_shamt   = 0;
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
               w_word = data_in[ch*IW +: IW];
               if (OFFSET_REL_TO_MSB != 0) w_shamt = IW - OW - int'(w_off_use);
               else                        w_shamt = int'(w_off_use);
               w_shifted = w_word >> w_shamt;
               w_slice[ch*OW +: OW] = w_shifted[OW-1:0];
            end
         end
      end else begin : g_unsupported
         assign w_slice = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n)             r_stage1 <= '0;
      else if (data_in_valid) r_stage1 <= w_slice;
   end

   generate
      if (LATENCY > 1) begin : g_data_dly
         slice_delay #(.WIDTH(DW), .DEPTH(LATENCY-1)) u_data_dly (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (r_stage1),
            .o_data (data_out)
         );
      end else begin : g_data_direct
         assign data_out = r_stage1;
      end
   endgenerate

   slice_delay #(.WIDTH(1), .DEPTH(LATENCY)) u_valid_dly (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (data_in_valid),
      .o_data (data_out_valid)
   );

   assign offset_active  = r_active;
   assign offset_pending = r_pending;
   assign offset_err     = r_err;

endmodule

// File: tb/tb_slice_dynamic.sv
// Directed bench for slice_dynamic: default MSB-relative instance and an
// LSB-relative, 2-channel, 3-cycle-latency instance.
module tb_slice_dynamic;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic       a_rst_n, a_valid, a_sync, a_load;
   logic [7:0] a_data_in;
   logic [2:0] a_offset_in;
   logic [4:0] a_data_out;
   logic       a_ov, a_pending, a_err;
   logic [2:0] a_active;

   logic        b_rst_n, b_valid, b_sync, b_load;
   logic [15:0] b_data_in;
   logic [2:0]  b_offset_in;
   logic [9:0]  b_data_out;
   logic        b_ov, b_pending, b_err;
   logic [2:0]  b_active;

   slice_dynamic u_a (
      .clk            (clk),
      .rst_n          (a_rst_n),
      .data_in        (a_data_in),
      .data_in_valid  (a_valid),
      .sync           (a_sync),
      .offset_in      (a_offset_in),
      .offset_load    (a_load),
      .data_out       (a_data_out),
      .data_out_valid (a_ov),
      .offset_active  (a_active),
      .offset_pending (a_pending),
      .offset_err     (a_err)
   );

   slice_dynamic #(
      .OFFSET_REL_TO_MSB (0),
      .LATENCY           (3),
      .NUM_CHANNELS      (2)
   ) u_b (
      .clk            (clk),
      .rst_n          (b_rst_n),
      .data_in        (b_data_in),
      .data_in_valid  (b_valid),
      .sync           (b_sync),
      .offset_in      (b_offset_in),
      .offset_load    (b_load),
      .data_out       (b_data_out),
      .data_out_valid (b_ov),
      .offset_active  (b_active),
      .offset_pending (b_pending),
      .offset_err     (b_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_rst_n = 0; a_valid = 0; a_sync = 0; a_load = 0; a_data_in = '0; a_offset_in = '0;
      b_rst_n = 0; b_valid = 0; b_sync = 0; b_load = 0; b_data_in = '0; b_offset_in = '0;
      tick; tick;
      chk("a_rst_out", 32'(a_data_out), 0);
      chk("a_rst_valid", 32'(a_ov), 0);
      chk("a_rst_active", 32'(a_active), 1);
      chk("a_rst_pending", 32'(a_pending), 0);
      chk("a_rst_err", 32'(a_err), 0);
      chk("b_rst_out", 32'(b_data_out), 0);
      chk("b_rst_active", 32'(b_active), 1);
      a_rst_n = 1; b_rst_n = 1;
      tick;

      // A: default offset 1 from MSB, 0x0F -> bits[6:2] = 00011
      a_data_in = 8'h0F; a_valid = 1;
      tick;
      a_valid = 0;
      chk("a_def_out", 32'(a_data_out), 3);
      chk("a_def_valid", 32'(a_ov), 1);
      chk("a_def_active", 32'(a_active), 1);
      tick;
      chk("a_idle_valid", 32'(a_ov), 0);
      chk("a_idle_hold", 32'(a_data_out), 3);

      // A: illegal load 4 (4+5>8)
      a_offset_in = 3'd4; a_load = 1;
      tick;
      a_load = 0;
      chk("a_bad_err", 32'(a_err), 1);
      chk("a_bad_pending", 32'(a_pending), 0);
      chk("a_bad_active", 32'(a_active), 1);

      // A: load 3 then commit on a valid sample -> bits[4:0] = 01111
      a_offset_in = 3'd3; a_load = 1;
      tick;
      a_load = 0;
      chk("a_ld3_pending", 32'(a_pending), 1);
      chk("a_ld3_active", 32'(a_active), 1);
      a_data_in = 8'h0F; a_valid = 1; a_sync = 1;
      tick;
      a_valid = 0; a_sync = 0;
      chk("a_cm3_out", 32'(a_data_out), 15);
      chk("a_cm3_valid", 32'(a_ov), 1);
      chk("a_cm3_pending", 32'(a_pending), 0);
      chk("a_cm3_active", 32'(a_active), 3);
      chk("a_err_sticky", 32'(a_err), 1);

      // A: load 0, then load 2 in the same cycle as the commit
      a_offset_in = 3'd0; a_load = 1;
      tick;
      a_load = 0;
      chk("a_ld0_pending", 32'(a_pending), 1);
      a_offset_in = 3'd2; a_load = 1; a_data_in = 8'h0F; a_valid = 1; a_sync = 1;
      tick;
      a_load = 0; a_valid = 0; a_sync = 0;
      chk("a_simul_out", 32'(a_data_out), 1);
      chk("a_simul_active", 32'(a_active), 0);
      chk("a_simul_pending", 32'(a_pending), 1);
      a_valid = 1; a_sync = 1;
      tick;
      a_valid = 0; a_sync = 0;
      chk("a_cm2_out", 32'(a_data_out), 7);
      chk("a_cm2_active", 32'(a_active), 2);
      chk("a_cm2_pending", 32'(a_pending), 0);

      // B: offset 2 from LSB, {F0,3C} -> {11100,01111}, valid 3 cycles later
      b_offset_in = 3'd2; b_load = 1;
      tick;
      b_load = 0;
      b_data_in = {8'hF0, 8'h3C}; b_valid = 1; b_sync = 1;
      tick;
      b_valid = 0; b_sync = 0;
      chk("b_lat_e1_valid", 32'(b_ov), 0);
      chk("b_cm2_active", 32'(b_active), 2);
      chk("b_cm2_pending", 32'(b_pending), 0);
      tick;
      chk("b_lat_e2_valid", 32'(b_ov), 0);
      tick;
      chk("b_lat_e3_valid", 32'(b_ov), 1);
      chk("b_lat_e3_out", 32'(b_data_out), 32'h38F);
      tick;
      chk("b_lat_e4_valid", 32'(b_ov), 0);
      chk("b_lat_e4_hold", 32'(b_data_out), 32'h38F);

      // B: load 2 then 3; sync without valid is ignored, sync with valid commits 3
      b_offset_in = 3'd2; b_load = 1;
      tick;
      b_offset_in = 3'd3;
      tick;
      b_load = 0; b_sync = 1;
      tick;
      chk("b_nov_pending", 32'(b_pending), 1);
      chk("b_nov_active", 32'(b_active), 2);
      chk("b_nov_valid", 32'(b_ov), 0);
      b_valid = 1;
      tick;
      b_valid = 0; b_sync = 0;
      chk("b_cm3_active", 32'(b_active), 3);
      chk("b_cm3_pending", 32'(b_pending), 0);
      tick; tick;
      chk("b_cm3_valid", 32'(b_ov), 1);
      chk("b_cm3_out", 32'(b_data_out), 32'h3C7);

      // B: reset with three samples in flight
      b_data_in = 16'hFFFF; b_valid = 1;
      tick; tick;
      b_rst_n = 0;
      tick;
      chk("b_mid_rst_valid", 32'(b_ov), 0);
      chk("b_mid_rst_out", 32'(b_data_out), 0);
      chk("b_mid_rst_active", 32'(b_active), 1);
      chk("b_mid_rst_pending", 32'(b_pending), 0);
      b_rst_n = 1; b_valid = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("b_post_rst_valid", 32'(b_ov), 0);
      end
      chk("b_post_rst_out", 32'(b_data_out), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
